// File: rtl/siggen_seq_ctrl.sv
// Signal-generator sequence controller.
// Drives clear/enable strobes and a slewed phase offset into the address
// counter.  The FSM walks IDLE -> CLEAR -> RUN -> DONE -> IDLE.
module siggen_seq_ctrl #(
  parameter int WIDTH = 9,
  parameter int IDX_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [DIV_W-1:0] i_rate,
  input  logic [IDX_W-1:0] i_burst_len,
  input  logic [WIDTH-1:0] i_offset_target,
  input  logic [WIDTH-1:0] i_offset_step,
  output logic             o_cnt_en,
  output logic             o_cnt_clr,
  output logic [WIDTH-1:0] o_offset,
  output logic [IDX_W-1:0] o_sample_idx,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_rate;
  logic [IDX_W-1:0] r_len;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_off;

  logic             w_strobe;
  logic             w_last;
  logic [IDX_W-1:0] w_idx_inc;
  logic [WIDTH:0]   w_tgt;
  logic [WIDTH:0]   w_cur;
  logic [WIDTH:0]   w_stp;
  logic [WIDTH:0]   w_dist;
  logic [WIDTH:0]   w_up;
  logic [WIDTH:0]   w_dn;
  logic [WIDTH-1:0] w_off_nxt;

  // A strobe is due when the divider reaches the latched rate; stop vetoes it
  // in the same cycle so the counter never advances on the way out.
  assign w_strobe  = (r_state == S_RUN) && (r_div == r_rate) && !i_stop;
  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_last    = (r_len != '0) && (w_idx_inc == r_len);

  // Offset slew toward the live target, one extra bit so nothing wraps.
  always_comb begin
    w_tgt     = {1'b0, i_offset_target};
    w_cur     = {1'b0, r_off};
    w_stp     = {1'b0, i_offset_step};
    w_dist    = (w_tgt >= w_cur) ? (w_tgt - w_cur) : (w_cur - w_tgt);
    w_up      = w_cur + w_stp;
    w_dn      = w_cur - w_stp;
    w_off_nxt = i_offset_target;
    if ((i_offset_step != '0) && (w_dist > w_stp)) begin
      w_off_nxt = (w_tgt > w_cur) ? w_up[WIDTH-1:0] : w_dn[WIDTH-1:0];
    end
  end

  // Sequencer FSM with divider, sample index and offset registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_rate  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_off   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_state <= S_CLEAR;
            r_rate  <= i_rate;
            r_len   <= i_burst_len;
          end
        end
        S_CLEAR: begin
          r_idx   <= '0;
          r_off   <= '0;
          r_div   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_stop) begin
            r_state <= S_DONE;
          end else if (r_div == r_rate) begin
            r_div <= '0;
            r_idx <= w_idx_inc;
            r_off <= w_off_nxt;
            if (w_last) r_state <= S_DONE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes and status decode straight from registered state; the only
  // input in the path is the stop veto on cnt_en.
  assign o_cnt_en     = w_strobe;
  assign o_cnt_clr    = (r_state == S_CLEAR);
  assign o_done       = (r_state == S_DONE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_offset     = r_off;
  assign o_sample_idx = r_idx;

endmodule

// File: doc/siggen_seq_ctrl.md
SIGGEN_SEQ_CTRL -- requirements
Module: siggen_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 9: address/offset width of the sequenced address counter.
REQ-002 Parameter IDX_W, default 16: width of burst length and sample index.
REQ-003 Parameter DIV_W, default 8: width of the sample-rate divider.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  request a sequence; level sampled each edge.
REQ-007 stop  input  1  abort the running sequence.
REQ-008 rate  input  DIV_W  divider; one sample every rate+1 RUN cycles.
REQ-009 burst_len  input  IDX_W  samples per sequence; 0 means continuous.
REQ-010 offset_target  input  WIDTH  desired phase offset; live, not latched.
REQ-011 offset_step  input  WIDTH  maximum offset change per sample; 0 means jump; live.
REQ-012 cnt_en  output  1  enable strobe to the address counter.
REQ-013 cnt_clr  output  1  synchronous clear strobe to the address counter.
REQ-014 offset  output  WIDTH  phase offset driven to the address counter.
REQ-015 sample_idx  output  IDX_W  number of cnt_en strobes issued in the current sequence.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle end-of-sequence pulse.

Function
REQ-018 The block SHALL implement the states IDLE, CLEAR, RUN and DONE in a registered FSM.
REQ-019 IDLE: start=1 and stop=0 at an edge SHALL move to CLEAR; rate and burst_len are latched at that edge.
REQ-020 CLEAR lasts exactly one cycle, with cnt_clr=1, sample_idx cleared to 0, offset cleared to 0 and divider cleared to 0, then moves to RUN.
REQ-021 RUN: the divider increments each cycle; cnt_en SHALL be high (decoded from registered state) in every cycle where divider==latched rate, and the divider SHALL return to 0 on that edge.
REQ-022 With rate=0, cnt_en SHALL be high in every RUN cycle; with rate=R, the first cnt_en SHALL occur in RUN cycle R+1.
REQ-023 On each cnt_en edge, sample_idx SHALL increment by 1; in continuous mode it SHALL wrap from all-ones to 0.
REQ-024 On each cnt_en edge, offset SHALL move toward offset_target by min(offset_step, |target-offset|); offset_step=0 SHALL load target directly; offset SHALL never overshoot or wrap (use WIDTH+1-bit arithmetic).
REQ-025 When burst_len!=0, the cnt_en edge that brings sample_idx to burst_len SHALL move to DONE.
REQ-026 stop=1 in RUN SHALL move to DONE at the next edge, and cnt_en SHALL be forced low in that cycle (stop wins over a due strobe).
REQ-027 DONE lasts one cycle with done=1, then moves to IDLE.
REQ-028 start SHALL be ignored while busy=1; start and stop together in IDLE SHALL leave the FSM in IDLE.
REQ-029 sample_idx and offset SHALL hold their final values in DONE/IDLE until the next CLEAR.
REQ-030 cnt_clr, cnt_en and done SHALL be mutually exclusive in any cycle.

Reset
REQ-031 rst=1 SHALL force, without waiting for a clock edge: state IDLE, cnt_en=0, cnt_clr=0, done=0, busy=0, offset=0, sample_idx=0, divider=0, latched rate=0, latched burst_len=0.
REQ-032 Reset asserted mid-sequence SHALL abort it without a done pulse; operation resumes only on a new start after rst deasserts.

Verification
REQ-033 rate=0, burst_len=4, step=0, target=5, start pulse at edge 0: CLEAR in cycle 1 (cnt_clr=1); cnt_en in cycles 2-5; offset=5 after the first strobe; done in cycle 6; busy=0 from cycle 7; sample_idx=4.
REQ-034 rate=2, burst_len=3: cnt_en exactly every 3rd RUN cycle (RUN cycles 3, 6, 9); done one cycle after the 3rd strobe.
REQ-035 rate=0, target=10, step=4, continuous: offset 4, 8, 10, 10; then target changed to 2: offset 6, 2, 2.
REQ-036 burst_len=0, stop asserted in the cycle a strobe is due: no cnt_en in that cycle; done next cycle; sample_idx holds its value.
REQ-037 start while busy has no effect; start+stop together in IDLE keeps busy=0; burst_len=0 runs past 0xFFFF and sample_idx wraps to 0.
REQ-038 rst asserted mid-RUN between edges: all outputs 0 immediately, no done pulse; a new start after release runs normally.
